blood_ph_sensor_sampler: RTL and testbench

BLOOD_PH_SENSOR_SAMPLER -- requirements
Module: blood_ph_sensor_sampler

---
 rtl/blood_ph_sensor_sampler.sv | 122 ++++++++++++
 tb/tb_blood_ph_sensor_sampler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/blood_ph_sensor_sampler.sv
// rtl/blood_ph_sensor_sampler.sv - serial pH frame receiver with 4-sample moving average
module blood_ph_sensor_sampler (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sensorStart,
  input  logic       sensorValid,
  input  logic       sensorBit,
  output logic [3:0] bloodPH,
  output logic       phValid,
  output logic       frameError,
  output logic       windowFull
);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, UPDATE} state_t;

  state_t state, state_next;

  logic [1:0]       bit_cnt;
  logic [3:0]       tmo_cnt;
  logic [3:0]       data;
  logic [3:0][3:0]  win;
  logic [5:0]       sum;
  logic [2:0]       count;

  logic [5:0] sum_new;
  logic [2:0] count_new;
  logic [3:0] avg;
  logic       frame_good;
  logic       timeout;

  logic restart, in_frame, shift_en, err_set, upd_en;

  // win[3] is the oldest entry; unused slots hold 0 so the sum stays exact while filling
  assign sum_new    = sum + {2'b00, data} - {2'b00, win[3]};
  assign count_new  = (count == 3'd4) ? 3'd4 : count + 3'd1;
  assign avg        = 4'((sum_new + 6'd2) >> 2);
  assign frame_good = ~(^{data, sensorBit}) && (data != 4'd15);
  assign timeout    = !sensorValid && (tmo_cnt == 4'd15);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (sensorStart) state_next = SHIFT;
      SHIFT: begin
        if (sensorStart)                            state_next = SHIFT;
        else if (sensorValid && bit_cnt == 2'd3)    state_next = PARITY;
        else if (timeout)                           state_next = IDLE;
      end
      PARITY: begin
        if (sensorStart)      state_next = SHIFT;
        else if (sensorValid) state_next = frame_good ? UPDATE : IDLE;
        else if (timeout)     state_next = IDLE;
      end
      UPDATE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    restart  = 1'b0;
    in_frame = 1'b0;
    shift_en = 1'b0;
    err_set  = 1'b0;
    upd_en   = 1'b0;
    case (state)
      IDLE:   restart = sensorStart;
      SHIFT, PARITY: begin
        restart  = sensorStart;
        in_frame = !sensorStart;
        shift_en = (state == SHIFT) && !sensorStart && sensorValid;
        err_set  = !sensorStart &&
                   (timeout || ((state == PARITY) && sensorValid && !frame_good));
      end
      UPDATE: upd_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt    <= 2'd0;
      tmo_cnt    <= 4'd0;
      data       <= 4'd0;
      win        <= '0;
      sum        <= 6'd0;
      count      <= 3'd0;
      bloodPH    <= 4'd0;
      phValid    <= 1'b0;
      frameError <= 1'b0;
      windowFull <= 1'b0;
    end else begin
      frameError <= err_set;
      phValid    <= upd_en && (count_new == 3'd4);
      if (restart) begin
        bit_cnt <= 2'd0;
        tmo_cnt <= 4'd0;
      end else begin
        if (shift_en) begin
          data    <= {data[2:0], sensorBit};
          bit_cnt <= bit_cnt + 2'd1;
        end
        if (in_frame && sensorValid) tmo_cnt <= 4'd0;
        else if (in_frame)           tmo_cnt <= tmo_cnt + 4'd1;
      end
      if (upd_en) begin
        win   <= {win[2:0], data};
        sum   <= sum_new;
        count <= count_new;
        if (count_new == 3'd4) begin
          bloodPH    <= avg;
          windowFull <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_blood_ph_sensor_sampler.sv
// tb/tb_blood_ph_sensor_sampler.sv - directed self-checking bench for blood_ph_sensor_sampler
module tb_blood_ph_sensor_sampler;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sensorStart = 1'b0;
  logic       sensorValid = 1'b0;
  logic       sensorBit = 1'b0;
  logic [3:0] bloodPH;
  logic       phValid;
  logic       frameError;
  logic       windowFull;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blood_ph_sensor_sampler dut (
    .clk        (clk),
    .rstn       (rstn),
    .sensorStart(sensorStart),
    .sensorValid(sensorValid),
    .sensorBit  (sensorBit),
    .bloodPH    (bloodPH),
    .phValid    (phValid),
    .frameError (frameError),
    .windowFull (windowFull)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [3:0] d, input logic p);
    for (int i = 3; i >= 0; i--) begin
      sensorValid = 1'b1;
      sensorBit   = d[i];
      cyc();
    end
    sensorBit = p;
    cyc();
    sensorValid = 1'b0;
    sensorBit   = 1'b0;
  endtask

  // fe0/ph0 sampled just after the parity edge E, ph1 just after E+1
  task automatic frame(input logic [3:0] d, input logic p,
                       output logic fe0, output logic ph0, output logic ph1);
    sensorStart = 1'b1;
    cyc();
    sensorStart = 1'b0;
    send_bits(d, p);
    fe0 = frameError;
    ph0 = phValid;
    cyc();
    ph1 = phValid;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cyc();
    cyc();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bloodPH !== 4'd0) begin errors++; $display("FAIL reset_bloodPH got %0d exp 0", bloodPH); end
    checks++; if (phValid !== 1'b0) begin errors++; $display("FAIL reset_phValid got %0b exp 0", phValid); end
    checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL reset_frameError got %0b exp 0", frameError); end
    checks++; if (windowFull !== 1'b0) begin errors++; $display("FAIL reset_windowFull got %0b exp 0", windowFull); end
    cyc();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic test_steady();
    logic fe0, ph0, ph1;
    for (int k = 1; k <= 4; k++) begin
      frame(4'd7, 1'b1, fe0, ph0, ph1);
      checks++; if (fe0 !== 1'b0) begin errors++; $display("FAIL steady_fe%0d got %0b exp 0", k, fe0); end
      if (k < 4) begin
        checks++; if (ph1 !== 1'b0) begin errors++; $display("FAIL steady_early_ph%0d got %0b exp 0", k, ph1); end
        checks++; if (windowFull !== 1'b0) begin errors++; $display("FAIL steady_wf%0d got %0b exp 0", k, windowFull); end
      end else begin
        checks++; if (ph1 !== 1'b1) begin errors++; $display("FAIL steady_ph got %0b exp 1", ph1); end
        checks++; if (bloodPH !== 4'd7) begin errors++; $display("FAIL steady_bloodPH got %0d exp 7", bloodPH); end
        checks++; if (windowFull !== 1'b1) begin errors++; $display("FAIL steady_wf got %0b exp 1", windowFull); end
      end
    end
    cyc();
    checks++; if (phValid !== 1'b0) begin errors++; $display("FAIL steady_pulse_width got %0b exp 0", phValid); end
  endtask

  task automatic test_averaging();
    logic [3:0] d  [5] = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd14};
    logic       p  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       ev [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] eb [5] = '{4'd0, 4'd0, 4'd0, 4'd8, 4'd10};
    logic fe0, ph0, ph1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      frame(d[k], p[k], fe0, ph0, ph1);
      checks++; if (ph1 !== ev[k]) begin errors++; $display("FAIL avg_ph%0d got %0b exp %0b", k, ph1, ev[k]); end
      checks++; if (bloodPH !== eb[k]) begin errors++; $display("FAIL avg_bloodPH%0d got %0d exp %0d", k, bloodPH, eb[k]); end
    end
  endtask

  task automatic test_reject();
    logic fe0, ph0, ph1;
    frame(4'd7, 1'b0, fe0, ph0, ph1);
    checks++; if (fe0 !== 1'b1) begin errors++; $display("FAIL reject_parity_fe got %0b exp 1", fe0); end
    checks++; if (ph1 !== 1'b0) begin errors++; $display("FAIL reject_parity_ph got %0b exp 0", ph1); end
    checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL reject_fe_width got %0b exp 0", frameError); end
    checks++; if (bloodPH !== 4'd10) begin errors++; $display("FAIL reject_bloodPH got %0d exp 10", bloodPH); end
    frame(4'd15, 1'b0, fe0, ph0, ph1);
    checks++; if (fe0 !== 1'b1) begin errors++; $display("FAIL reject_range_fe got %0b exp 1", fe0); end
    checks++; if (ph1 !== 1'b0) begin errors++; $display("FAIL reject_range_ph got %0b exp 0", ph1); end
    // window must still be 7,8,9,14: adding 2 gives 8,9,14,2 -> 33 -> 8
    frame(4'd2, 1'b1, fe0, ph0, ph1);
    checks++; if (ph1 !== 1'b1) begin errors++; $display("FAIL reject_after_ph got %0b exp 1", ph1); end
    checks++; if (bloodPH !== 4'd8) begin errors++; $display("FAIL reject_after_bloodPH got %0d exp 8", bloodPH); end
  endtask

  task automatic test_timeout();
    logic fe0, ph0, ph1;
    int n;
    sensorStart = 1'b1;
    cyc();
    sensorStart = 1'b0;
    sensorValid = 1'b1;
    sensorBit   = 1'b1;
    cyc();
    sensorBit = 1'b0;
    cyc();
    sensorValid = 1'b0;
    n = 0;
    while (n < 40 && frameError !== 1'b1) begin
      cyc();
      n++;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL timeout_cycles got %0d exp 16", n); end
    frame(4'd5, 1'b0, fe0, ph0, ph1);
    checks++; if (fe0 !== 1'b0) begin errors++; $display("FAIL timeout_next_fe got %0b exp 0", fe0); end
    checks++; if (ph1 !== 1'b1) begin errors++; $display("FAIL timeout_next_ph got %0b exp 1", ph1); end
    checks++; if (bloodPH !== 4'd8) begin errors++; $display("FAIL timeout_next_bloodPH got %0d exp 8", bloodPH); end
  endtask

  task automatic test_restart();
    sensorStart = 1'b1;
    cyc();
    sensorStart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sensorValid = 1'b1;
      sensorBit   = 1'b1;
      cyc();
    end
    sensorStart = 1'b1;
    cyc();
    sensorStart = 1'b0;
    checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL restart_fe got %0b exp 0", frameError); end
    send_bits(4'd3, 1'b0);
    checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL restart_frame_fe got %0b exp 0", frameError); end
    cyc();
    checks++; if (phValid !== 1'b1) begin errors++; $display("FAIL restart_ph got %0b exp 1", phValid); end
    checks++; if (bloodPH !== 4'd6) begin errors++; $display("FAIL restart_bloodPH got %0d exp 6", bloodPH); end
  endtask

  task automatic test_reset_mid();
    logic fe0, ph0, ph1;
    for (int k = 0; k < 3; k++) begin
      frame(4'd4, 1'b1, fe0, ph0, ph1);
      checks++; if (ph1 !== 1'b1) begin errors++; $display("FAIL rmid_pre_ph%0d got %0b exp 1", k, ph1); end
    end
    checks++; if (bloodPH !== 4'd4) begin errors++; $display("FAIL rmid_pre_bloodPH got %0d exp 4", bloodPH); end
    sensorStart = 1'b1;
    cyc();
    sensorStart = 1'b0;
    sensorValid = 1'b1;
    sensorBit   = 1'b1;
    cyc();
    cyc();
    rstn = 1'b0;
    #2;
    checks++; if (bloodPH !== 4'd0) begin errors++; $display("FAIL rmid_async_bloodPH got %0d exp 0", bloodPH); end
    checks++; if (windowFull !== 1'b0) begin errors++; $display("FAIL rmid_async_wf got %0b exp 0", windowFull); end
    sensorValid = 1'b0;
    sensorBit   = 1'b0;
    cyc();
    rstn = 1'b1;
    cyc();
    for (int k = 1; k <= 4; k++) begin
      frame(4'd4, 1'b1, fe0, ph0, ph1);
      if (k < 4) begin
        checks++; if (ph1 !== 1'b0) begin errors++; $display("FAIL rmid_post_ph%0d got %0b exp 0", k, ph1); end
      end else begin
        checks++; if (ph1 !== 1'b1) begin errors++; $display("FAIL rmid_post_ph got %0b exp 1", ph1); end
        checks++; if (bloodPH !== 4'd4) begin errors++; $display("FAIL rmid_post_bloodPH got %0d exp 4", bloodPH); end
      end
    end
  endtask

  task automatic test_latency();
    logic fe0, ph0, ph1;
    frame(4'd9, 1'b0, fe0, ph0, ph1);
    checks++; if (ph0 !== 1'b0) begin errors++; $display("FAIL lat_edgeE got %0b exp 0", ph0); end
    checks++; if (ph1 !== 1'b1) begin errors++; $display("FAIL lat_edgeE1 got %0b exp 1", ph1); end
    checks++; if (bloodPH !== 4'd5) begin errors++; $display("FAIL lat_bloodPH got %0d exp 5", bloodPH); end
    cyc();
    checks++; if (phValid !== 1'b0) begin errors++; $display("FAIL lat_edgeE2 got %0b exp 0", phValid); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_averaging();
    test_reject();
    test_timeout();
    test_restart();
    test_reset_mid();
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
